// File: rtl/tdp_mem_be.sv
//============================================================================
// Module   : tdp_mem_be
// Brief    : Single-clock true dual-port memory with per-byte write enables,
//            1- or 2-cycle read latency, cross-port read-during-write
//            control, port-A-wins write-write resolution and a collision
//            flag.
//            Optional macro TDP_MEM_PARITY_EN adds one even-parity bit per
//            byte lane with a parity-flip test hook and per-port parity
//            error outputs.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tdp_mem_be #(
    parameter int DATA_WIDTH    = 32,
    parameter int BYTE_WIDTH    = 8,
    parameter int DATA_DEPTH    = 64,
    parameter int ADDR_WIDTH    = $clog2(DATA_DEPTH),
    parameter int NUM_BYTES     = DATA_WIDTH / BYTE_WIDTH,
    parameter int READ_LATENCY  = 1,
    parameter int RDW_MODE      = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  a_en_i,
    input  logic                  a_we_i,
    input  logic [NUM_BYTES-1:0]  a_be_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [DATA_WIDTH-1:0] a_wdata_i,
    output logic [DATA_WIDTH-1:0] a_rdata_o,
    output logic                  a_rvalid_o,
    output logic                  a_perr_o,
    input  logic                  b_en_i,
    input  logic                  b_we_i,
    input  logic [NUM_BYTES-1:0]  b_be_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [DATA_WIDTH-1:0] b_wdata_i,
    output logic [DATA_WIDTH-1:0] b_rdata_o,
    output logic                  b_rvalid_o,
    output logic                  b_perr_o,
    input  logic                  par_flip_i,
    output logic                  collision_o
);

    // Index width of the storage array; the address port may be wider so
    // that out-of-range addresses can be presented and rejected.
    localparam int                c_idx_w = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH + 1)'(DATA_DEPTH);

    // Storage
    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

    // Port views: index 0 = port A, index 1 = port B
    logic [1:0]            w_en;
    logic [1:0]            w_we;
    logic [NUM_BYTES-1:0]  w_be    [2];
    logic [ADDR_WIDTH-1:0] w_addr  [2];
    logic [DATA_WIDTH-1:0] w_wdata [2];

    assign w_en       = {b_en_i, a_en_i};
    assign w_we       = {b_we_i, a_we_i};
    assign w_be[0]    = a_be_i;
    assign w_be[1]    = b_be_i;
    assign w_addr[0]  = a_addr_i;
    assign w_addr[1]  = b_addr_i;
    assign w_wdata[0] = a_wdata_i;
    assign w_wdata[1] = b_wdata_i;

    logic [1:0]            w_inrange;
    logic [1:0]            w_wr;
    logic [1:0]            w_rd;
    logic [c_idx_w-1:0]    w_idx   [2];
    logic [DATA_WIDTH-1:0] w_rword [2];
    logic [1:0]            w_perr;

    // Request decode: writes outside the array are dropped here so neither
    // storage nor the collision flag ever sees them.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_inrange[p] = ({1'b0, w_addr[p]} < c_depth);
            w_idx[p]     = w_addr[p][c_idx_w-1:0];
            w_wr[p]      = w_en[p] & w_we[p] & w_inrange[p];
            w_rd[p]      = w_en[p] & ~w_we[p];
        end
    end

    // Read word per port; in new-data mode the other port's written lanes
    // are bypassed into the result.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rword[p] = w_inrange[p] ? mem_q[w_idx[p]] : '0;
            if ((RDW_MODE == 1) && w_inrange[p] && w_wr[1-p] &&
                (w_addr[1-p] == w_addr[p])) begin
                for (int l = 0; l < NUM_BYTES; l++) begin
                    if (w_be[1-p][l]) begin
                        w_rword[p][l*BYTE_WIDTH +: BYTE_WIDTH] =
                            w_wdata[1-p][l*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

`ifdef TDP_MEM_PARITY_EN
    logic [NUM_BYTES-1:0] par_q  [DATA_DEPTH];
    logic [NUM_BYTES-1:0] w_wpar [2];
    logic [NUM_BYTES-1:0] w_rpar [2];
    logic [NUM_BYTES-1:0] w_calc [2];

    // Parity generation on write, stored-parity fetch (with the same bypass
    // as the data) and mismatch detection on read.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            for (int l = 0; l < NUM_BYTES; l++) begin
                w_wpar[p][l] = (^w_wdata[p][l*BYTE_WIDTH +: BYTE_WIDTH]) ^ par_flip_i;
            end
        end
        for (int p = 0; p < 2; p++) begin
            w_rpar[p] = w_inrange[p] ? par_q[w_idx[p]] : '0;
            if ((RDW_MODE == 1) && w_inrange[p] && w_wr[1-p] &&
                (w_addr[1-p] == w_addr[p])) begin
                for (int l = 0; l < NUM_BYTES; l++) begin
                    if (w_be[1-p][l]) begin
                        w_rpar[p][l] = w_wpar[1-p][l];
                    end
                end
            end
            for (int l = 0; l < NUM_BYTES; l++) begin
                w_calc[p][l] = ^w_rword[p][l*BYTE_WIDTH +: BYTE_WIDTH];
            end
            w_perr[p] = w_inrange[p] & (|(w_calc[p] ^ w_rpar[p]));
        end
    end
`else
    logic w_unused_par_flip;
    assign w_unused_par_flip = par_flip_i;

    // No parity storage: errors can never be reported.
    always_comb begin
        w_perr = '0;
    end
`endif

    // Storage update. Port B lanes are written first and port A last, so
    // port A wins any lane both ports enable at the same address.
    generate
        if (INIT_ON_RESET != 0) begin : g_init_mem
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    for (int i = 0; i < DATA_DEPTH; i++) begin
                        mem_q[i] <= '0;
`ifdef TDP_MEM_PARITY_EN
                        par_q[i] <= '0;
`endif
                    end
                end else begin
                    for (int p = 1; p >= 0; p--) begin
                        if (w_wr[p]) begin
                            for (int l = 0; l < NUM_BYTES; l++) begin
                                if (w_be[p][l]) begin
                                    mem_q[w_idx[p]][l*BYTE_WIDTH +: BYTE_WIDTH] <=
                                        w_wdata[p][l*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef TDP_MEM_PARITY_EN
                                    par_q[w_idx[p]][l] <= w_wpar[p][l];
`endif
                                end
                            end
                        end
                    end
                end
            end
        end else begin : g_keep_mem
            always_ff @(posedge clk_i) begin
                for (int p = 1; p >= 0; p--) begin
                    if (w_wr[p]) begin
                        for (int l = 0; l < NUM_BYTES; l++) begin
                            if (w_be[p][l]) begin
                                mem_q[w_idx[p]][l*BYTE_WIDTH +: BYTE_WIDTH] <=
                                    w_wdata[p][l*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef TDP_MEM_PARITY_EN
                                par_q[w_idx[p]][l] <= w_wpar[p][l];
`endif
                            end
                        end
                    end
                end
            end
        end
    endgenerate

    // Read pipeline and collision flag state
    logic [DATA_WIDTH-1:0] s1_data_d [2];
    logic [DATA_WIDTH-1:0] s1_data_q [2];
    logic [DATA_WIDTH-1:0] rdata_d   [2];
    logic [DATA_WIDTH-1:0] rdata_q   [2];
    logic [1:0]            s1_vld_d, s1_vld_q;
    logic [1:0]            s1_perr_d, s1_perr_q;
    logic [1:0]            rvalid_d, rvalid_q;
    logic [1:0]            perr_d, perr_q;
    logic                  collision_d, collision_q;

    // Next-state for the read pipeline: rdata/perr hold between reads,
    // rvalid is a single-cycle pulse per read.
    always_comb begin
        collision_d = w_wr[0] & w_wr[1] & (w_addr[0] == w_addr[1]) &
                      (|(w_be[0] & w_be[1]));
        for (int p = 0; p < 2; p++) begin
            s1_vld_d[p]  = w_rd[p];
            s1_data_d[p] = w_rd[p] ? w_rword[p] : s1_data_q[p];
            s1_perr_d[p] = w_rd[p] ? w_perr[p]  : s1_perr_q[p];
            if (READ_LATENCY == 2) begin
                rvalid_d[p] = s1_vld_q[p];
                rdata_d[p]  = s1_vld_q[p] ? s1_data_q[p] : rdata_q[p];
                perr_d[p]   = s1_vld_q[p] ? s1_perr_q[p] : perr_q[p];
            end else begin
                rvalid_d[p] = w_rd[p];
                rdata_d[p]  = w_rd[p] ? w_rword[p] : rdata_q[p];
                perr_d[p]   = w_rd[p] ? w_perr[p]  : perr_q[p];
            end
        end
    end

    // Pipeline registers; reset drops any read in flight.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int p = 0; p < 2; p++) begin
                s1_data_q[p] <= '0;
                rdata_q[p]   <= '0;
            end
            s1_vld_q    <= '0;
            s1_perr_q   <= '0;
            rvalid_q    <= '0;
            perr_q      <= '0;
            collision_q <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                s1_data_q[p] <= s1_data_d[p];
                rdata_q[p]   <= rdata_d[p];
            end
            s1_vld_q    <= s1_vld_d;
            s1_perr_q   <= s1_perr_d;
            rvalid_q    <= rvalid_d;
            perr_q      <= perr_d;
            collision_q <= collision_d;
        end
    end

    assign a_rdata_o   = rdata_q[0];
    assign b_rdata_o   = rdata_q[1];
    assign a_rvalid_o  = rvalid_q[0];
    assign b_rvalid_o  = rvalid_q[1];
    assign a_perr_o    = perr_q[0];
    assign b_perr_o    = perr_q[1];
    assign collision_o = collision_q;

endmodule

`default_nettype wire

// File: tb/tb_tdp_mem_be.sv
//============================================================================
// Module   : tb_tdp_mem_be
// Brief    : Directed self-checking bench for tdp_mem_be (2-cycle latency,
//            new-data read-during-write, clear on reset, 7-bit address so
//            address 64 is out of range).
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_tdp_mem_be;

`ifdef TDP_MEM_PARITY_EN
    localparam logic c_flip_perr = 1'b1;
`else
    localparam logic c_flip_perr = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        a_en, a_we, b_en, b_we, par_flip;
    logic [3:0]  a_be, b_be;
    logic [6:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic [31:0] a_rdata, b_rdata;
    logic        a_rvalid, b_rvalid, a_perr, b_perr, collision;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tdp_mem_be #(
        .DATA_WIDTH    (32),
        .BYTE_WIDTH    (8),
        .DATA_DEPTH    (64),
        .ADDR_WIDTH    (7),
        .READ_LATENCY  (2),
        .RDW_MODE      (1),
        .INIT_ON_RESET (1)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .a_en_i      (a_en),
        .a_we_i      (a_we),
        .a_be_i      (a_be),
        .a_addr_i    (a_addr),
        .a_wdata_i   (a_wdata),
        .a_rdata_o   (a_rdata),
        .a_rvalid_o  (a_rvalid),
        .a_perr_o    (a_perr),
        .b_en_i      (b_en),
        .b_we_i      (b_we),
        .b_be_i      (b_be),
        .b_addr_i    (b_addr),
        .b_wdata_i   (b_wdata),
        .b_rdata_o   (b_rdata),
        .b_rvalid_o  (b_rvalid),
        .b_perr_o    (b_perr),
        .par_flip_i  (par_flip),
        .collision_o (collision)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        a_en = 0; a_we = 0; a_be = '0; a_addr = '0; a_wdata = '0;
        b_en = 0; b_we = 0; b_be = '0; b_addr = '0; b_wdata = '0;
        par_flip = 0;
    endtask

    task automatic set_a(input logic we, input logic [6:0] addr, input logic [3:0] be,
                         input logic [31:0] data);
        a_en = 1; a_we = we; a_addr = addr; a_be = be; a_wdata = data;
    endtask

    task automatic set_b(input logic we, input logic [6:0] addr, input logic [3:0] be,
                         input logic [31:0] data);
        b_en = 1; b_we = we; b_addr = addr; b_be = be; b_wdata = data;
    endtask

    // Single write on one port, one cycle wide
    task automatic wr(input bit port, input logic [6:0] addr, input logic [3:0] be,
                      input logic [31:0] data, input logic flip);
        @(negedge clk);
        idle();
        if (port == 1'b0) set_a(1'b1, addr, be, data);
        else              set_b(1'b1, addr, be, data);
        par_flip = flip;
        @(negedge clk);
        idle();
    endtask

    // Single read with latency, pulse-width and hold checks
    task automatic rd_chk(input bit port, input logic [6:0] addr, input logic [31:0] exp_d,
                          input logic exp_p, input string tag);
        @(negedge clk);
        idle();
        if (port == 1'b0) set_a(1'b0, addr, 4'h0, 32'h0);
        else              set_b(1'b0, addr, 4'h0, 32'h0);
        @(negedge clk);
        idle();
        chk({tag, "_early"}, {31'b0, port ? b_rvalid : a_rvalid}, 32'd0);
        @(negedge clk);
        chk({tag, "_vld"},  {31'b0, port ? b_rvalid : a_rvalid}, 32'd1);
        chk({tag, "_data"}, port ? b_rdata : a_rdata, exp_d);
        chk({tag, "_perr"}, {31'b0, port ? b_perr : a_perr}, {31'b0, exp_p});
        @(negedge clk);
        chk({tag, "_pulse"}, {31'b0, port ? b_rvalid : a_rvalid}, 32'd0);
        chk({tag, "_hold"},  port ? b_rdata : a_rdata, exp_d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a_rdata",  a_rdata, 32'h0);
        chk("rst_b_rdata",  b_rdata, 32'h0);
        chk("rst_a_rvalid", {31'b0, a_rvalid}, 32'd0);
        chk("rst_b_rvalid", {31'b0, b_rvalid}, 32'd0);
        chk("rst_a_perr",   {31'b0, a_perr}, 32'd0);
        chk("rst_b_perr",   {31'b0, b_perr}, 32'd0);
        chk("rst_coll",     {31'b0, collision}, 32'd0);
        rstn = 1'b1;

        // Basic write on A, read on B
        wr(0, 7'd5, 4'hF, 32'hDEADBEEF, 1'b0);
        rd_chk(1, 7'd5, 32'hDEADBEEF, 1'b0, "b_rd5");

        // Byte-lane write
        wr(0, 7'd3, 4'hF, 32'h11223344, 1'b0);
        wr(0, 7'd3, 4'h5, 32'hAABBCCDD, 1'b0);
        rd_chk(0, 7'd3, 32'h11BB33DD, 1'b0, "a_rd3_be");

        // Cross-port read-during-write, full word, new data returned
        wr(1, 7'd7, 4'hF, 32'h0, 1'b0);
        @(negedge clk);
        idle();
        set_a(1'b0, 7'd7, 4'h0, 32'h0);
        set_b(1'b1, 7'd7, 4'hF, 32'hCAFEF00D);
        @(negedge clk);
        idle();
        chk("rdw_early", {31'b0, a_rvalid}, 32'd0);
        @(negedge clk);
        chk("rdw_vld",  {31'b0, a_rvalid}, 32'd1);
        chk("rdw_data", a_rdata, 32'hCAFEF00D);
        chk("rdw_b_norvalid", {31'b0, b_rvalid}, 32'd0);

        // Partial-lane read-during-write: only written lanes bypassed
        @(negedge clk);
        set_a(1'b0, 7'd7, 4'h0, 32'h0);
        set_b(1'b1, 7'd7, 4'h3, 32'h12345678);
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("rdw_part_data", a_rdata, 32'hCAFE5678);
        rd_chk(0, 7'd7, 32'hCAFE5678, 1'b0, "rdw_part_stored");

        // be = 0 is a no-op
        wr(0, 7'd7, 4'h0, 32'hFFFFFFFF, 1'b0);
        rd_chk(1, 7'd7, 32'hCAFE5678, 1'b0, "be0_noop");

        // Write-write collision with lane overlap: A wins lane 0
        @(negedge clk);
        set_a(1'b1, 7'd9, 4'h1, 32'h000000AA);
        set_b(1'b1, 7'd9, 4'h3, 32'hBBBBBBBB);
        @(negedge clk);
        idle();
        chk("coll_pulse", {31'b0, collision}, 32'd1);
        @(negedge clk);
        chk("coll_once", {31'b0, collision}, 32'd0);
        rd_chk(0, 7'd9, 32'h0000BBAA, 1'b0, "ww_merge");

        // Same address, disjoint lanes: no collision
        @(negedge clk);
        set_a(1'b1, 7'd9, 4'h1, 32'h00000011);
        set_b(1'b1, 7'd9, 4'h2, 32'h00002200);
        @(negedge clk);
        idle();
        chk("disjoint_nocoll", {31'b0, collision}, 32'd0);
        @(negedge clk);
        chk("disjoint_nocoll2", {31'b0, collision}, 32'd0);
        rd_chk(1, 7'd9, 32'h00002211, 1'b0, "disjoint_merge");

        // Different addresses, overlapping lanes: no collision
        @(negedge clk);
        set_a(1'b1, 7'd10, 4'hF, 32'h0A0A0A0A);
        set_b(1'b1, 7'd11, 4'hF, 32'h0B0B0B0B);
        @(negedge clk);
        idle();
        chk("diffaddr_nocoll", {31'b0, collision}, 32'd0);
        rd_chk(0, 7'd10, 32'h0A0A0A0A, 1'b0, "diffaddr_a");
        rd_chk(1, 7'd11, 32'h0B0B0B0B, 1'b0, "diffaddr_b");

        // Out-of-range writes on both ports: ignored, no collision
        @(negedge clk);
        set_a(1'b1, 7'd64, 4'hF, 32'h55555555);
        set_b(1'b1, 7'd64, 4'hF, 32'h66666666);
        @(negedge clk);
        idle();
        chk("oor_nocoll", {31'b0, collision}, 32'd0);
        rd_chk(0, 7'd64, 32'h0, 1'b0, "oor_rd");
        rd_chk(1, 7'd0, 32'h0, 1'b0, "oor_wr_ignored");

        // Both ports read the same address in the same cycle
        @(negedge clk);
        set_a(1'b0, 7'd3, 4'h0, 32'h0);
        set_b(1'b0, 7'd3, 4'h0, 32'h0);
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("dual_a_vld",  {31'b0, a_rvalid}, 32'd1);
        chk("dual_b_vld",  {31'b0, b_rvalid}, 32'd1);
        chk("dual_a_data", a_rdata, 32'h11BB33DD);
        chk("dual_b_data", b_rdata, 32'h11BB33DD);

        // Parity flip hook
        wr(0, 7'd2, 4'h1, 32'h0000005A, 1'b1);
        rd_chk(0, 7'd2, 32'h0000005A, c_flip_perr, "par_flip");
        rd_chk(1, 7'd5, 32'hDEADBEEF, 1'b0, "par_clean");

        // Back-to-back reads, then reset mid-stream
        @(negedge clk);
        set_a(1'b0, 7'd5, 4'h0, 32'h0);
        @(negedge clk);
        chk("pipe_early", {31'b0, a_rvalid}, 32'd0);
        set_a(1'b0, 7'd3, 4'h0, 32'h0);
        @(negedge clk);
        chk("pipe0_vld",  {31'b0, a_rvalid}, 32'd1);
        chk("pipe0_data", a_rdata, 32'hDEADBEEF);
        set_a(1'b0, 7'd9, 4'h0, 32'h0);
        @(negedge clk);
        chk("pipe1_vld",  {31'b0, a_rvalid}, 32'd1);
        chk("pipe1_data", a_rdata, 32'h11BB33DD);
        set_a(1'b0, 7'd10, 4'h0, 32'h0);
        #1 rstn = 1'b0;
        #1;
        chk("rst_async_rdata",  a_rdata, 32'h0);
        chk("rst_async_rvalid", {31'b0, a_rvalid}, 32'd0);
        idle();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_flush_vld",  {31'b0, a_rvalid}, 32'd0);
            chk("rst_flush_data", a_rdata, 32'h0);
        end
        rd_chk(0, 7'd9, 32'h0, 1'b0, "init_clr9");
        rd_chk(1, 7'd5, 32'h0, 1'b0, "init_clr5");
        rd_chk(0, 7'd3, 32'h0, 1'b0, "init_clr3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tdp_mem_be.md
Name: tdp_mem_be

Overview:
- Single-clock true dual-port memory with two symmetric read/write ports (A, B), per-byte write enables and configurable read latency (1 or 2).
- Defines cross-port read-during-write semantics and write-write collision resolution, and flags collisions.
- Successor to the team's simple one-read/one-write memory; the building block for the packet buffers and register-file shadows.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, bits per write-enable lane.
- DATA_DEPTH, 64, number of words; need not be a power of 2.
- ADDR_WIDTH, $clog2(DATA_DEPTH), address width.
- NUM_BYTES, DATA_WIDTH/BYTE_WIDTH, number of byte lanes (derived; do not override).
- READ_LATENCY, 1, cycles from read request to data; legal values 1 or 2.
- RDW_MODE, 0, cross-port read-during-write: 0 = old data, 1 = new (bypassed) data.
- INIT_ON_RESET, 1, when 1 all words are cleared on reset; when 0 contents are untouched by reset.

Ports:
- clk_i  input  1  system clock
- rstn_i  input  1  asynchronous active-low reset
- a_en_i  input  1  port A access request
- a_we_i  input  1  port A write (1) / read (0)
- a_be_i  input  NUM_BYTES  port A byte-lane enables (write only)
- a_addr_i  input  ADDR_WIDTH  port A address
- a_wdata_i  input  DATA_WIDTH  port A write data
- a_rdata_o  output  DATA_WIDTH  port A read data
- a_rvalid_o  output  1  port A read data valid, one-cycle pulse
- a_perr_o  output  1  port A parity error, qualified by a_rvalid_o
- b_*  same set as port A, for port B
- par_flip_i  input  1  invert stored parity of bytes written this cycle (test hook)
- collision_o  output  1  write-write byte overlap pulse

Behaviour:
- Reset (async assert, sync release): all rdata = 0, rvalid = 0, perr = 0, collision_o = 0; all read pipeline stages flushed.
  - If INIT_ON_RESET = 1, every word and parity bit is cleared.
  - A read in flight when reset asserts is dropped and never produces rvalid.
- Read: en = 1, we = 0 at cycle N.
  - READ_LATENCY = 1: rdata and rvalid appear at N+1.
  - READ_LATENCY = 2: they appear at N+2.
  - Back-to-back reads give one result per cycle, fully pipelined.
- Between reads, rdata holds its last value; rvalid = 0.
- Write: en = 1, we = 1. Only lanes with be = 1 are updated at the clock edge. be = 0 is a legal no-op. Writes never assert rvalid.
- Cross-port read-during-write (A reads X while B writes X, or the reverse):
  - RDW_MODE = 0: returned word is the pre-write contents.
  - RDW_MODE = 1: returned word has the written lanes replaced by the new data; unwritten lanes are old.
- Write-write same address, same cycle:
  - Resolved per lane; port A wins any lane both ports enable.
  - Lanes enabled by only one port take that port's data.
  - collision_o = 1 at N+1 for exactly one cycle if any lane overlaps.
  - Different addresses, or disjoint lanes: no collision.
- Address >= DATA_DEPTH: write ignored; read returns 0 with rvalid asserted; no collision is reported.
- Reads on both ports to the same address are always legal.

Optional Feature:
- Macro: TDP_MEM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte lane and written alongside the data.
  - par_flip_i inverts the stored bit for the lanes written that cycle.
  - On a read, perr is asserted with rvalid if any lane's parity mismatches; it is pipelined identically to rdata.
  - Out-of-range reads give perr = 0.
- Not defined: no parity storage is built; perr outputs are tied to 0 and par_flip_i is ignored.

Test Plan:
- Reset, then write A addr 5 = 0xDEADBEEF, be = 0xF; read B addr 5 → b_rdata_o = 0xDEADBEEF, b_rvalid_o one cycle later (READ_LATENCY = 1) or two cycles later (READ_LATENCY = 2).
- Addr 3 = 0x11223344; write A be = 0x5, data 0xAABBCCDD → read returns 0x11BB33DD.
- Addr 7 = 0; A reads 7 while B writes 0xCAFEF00D → a_rdata_o = 0x00000000 (RDW_MODE = 0) or 0xCAFEF00D (RDW_MODE = 1).
- Same cycle at addr 9: A writes 0x000000AA with be = 0x1, B writes 0xBBBBBBBB with be = 0x3 → word = 0x0000BBAA; collision_o pulses once. Repeat with B be = 0x2 → no pulse.
- Issue 4 back-to-back reads with READ_LATENCY = 2, then assert rstn_i low mid-stream → no rvalid after reset; rdata = 0; with INIT_ON_RESET = 1, all addresses read 0 afterwards.
- With TDP_MEM_PARITY_EN: write addr 2 with par_flip_i = 1, be = 0x1 → read addr 2 gives a_perr_o = 1; read an untouched address → perr = 0. Out-of-range read at addr 64 → rdata = 0, perr = 0.
